// File: rtl/fetch_unit.sv
// Instruction-fetch stage: program counter, one-entry fetch buffer and IR, with RAM read sequencing.
// Optional FETCH_PERF_EN adds saturating fetch/squash counters (fetch_count, squash_count).
module fetch_unit #(
    parameter int ADDR_W  = 11,
    parameter int INSTR_W = 32,
    parameter int RAM_LAT = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clear_pc,
    input  logic               load_pc,
    input  logic               load_ir,
    input  logic               branch_en,
    input  logic [ADDR_W-1:0]  branch_addr,
    output logic               ram_rd_en,
    output logic [ADDR_W-1:0]  ram_addr1,
    input  logic [INSTR_W-1:0] ram_rdata,
    output logic [ADDR_W-1:0]  pc,
    output logic [INSTR_W-1:0] instr,
    output logic [3:0]         cond,
    output logic [6:0]         opcode,
    output logic               P,
    output logic               U,
    output logic               W,
    output logic               buf_valid,
    output logic               busy,
    output logic               underrun
`ifdef FETCH_PERF_EN
    ,
    output logic [15:0]        fetch_count,
    output logic [15:0]        squash_count
`endif
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, FULL} state_t;

    localparam logic [1:0] LAT_INIT = 2'(RAM_LAT - 1);

    state_t             state_q, state_d;
    logic [1:0]         lat_cnt;
    logic [INSTR_W-1:0] buf_data;
    logic               redirect;
    logic               capture;
    logic               take_ir;
    logic               underrun_set;

    // clear_pc and branch_en both abandon whatever the FSM was doing this cycle.
    assign redirect = clear_pc | branch_en;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        state_d = state_q;
        capture = 1'b0;
        take_ir = 1'b0;
        unique case (state_q)
            IDLE: if (load_pc && !load_ir) state_d = REQ;
            REQ:  state_d = WAIT;
            WAIT: begin
                if (lat_cnt == 2'd0) begin
                    state_d = FULL;
                    capture = 1'b1;
                end
            end
            FULL: begin
                if (load_ir) begin
                    state_d = IDLE;
                    take_ir = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        if (redirect) begin
            state_d = IDLE;
            capture = 1'b0;
            take_ir = 1'b0;
        end
    end

    assign underrun_set = load_ir && (state_q != FULL) && !redirect;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            pc        <= '0;
            instr     <= '0;
            ram_rd_en <= 1'b0;
            ram_addr1 <= '0;
            underrun  <= 1'b0;
            lat_cnt   <= 2'd0;
        end else begin
            state_q   <= state_d;
            ram_rd_en <= (state_d == REQ);
            if (state_d == REQ) ram_addr1 <= pc;

            if (state_q == REQ)
                lat_cnt <= LAT_INIT;
            else if (state_q == WAIT && lat_cnt != 2'd0)
                lat_cnt <= lat_cnt - 2'd1;

            if (clear_pc) begin
                pc       <= '0;
                instr    <= '0;
                underrun <= 1'b0;
            end else if (branch_en) begin
                pc <= branch_addr;
            end else begin
                if (take_ir) begin
                    instr <= buf_data;
                    pc    <= pc + 1'b1;
                end
                if (underrun_set) underrun <= 1'b1;
            end
        end
    end

    // NOTE: the buffer word is qualified by state FULL, so its data register needs no reset.
    always_ff @(posedge clk) begin
        if (capture) buf_data <= ram_rdata;
    end

    assign buf_valid = (state_q == FULL);
    assign busy      = (state_q == REQ) || (state_q == WAIT);

    assign cond   = instr[31:28];
    assign opcode = instr[27:21];
    assign P      = instr[20];
    assign U      = instr[19];
    assign W      = instr[18];

`ifdef FETCH_PERF_EN
    logic squash;
    assign squash = redirect && busy;

    always_ff @(posedge clk) begin
        if (!rst_n || clear_pc) begin
            fetch_count  <= 16'd0;
            squash_count <= 16'd0;
        end else begin
            if (capture && fetch_count != 16'hFFFF) fetch_count <= fetch_count + 16'd1;
            if (squash && squash_count != 16'hFFFF) squash_count <= squash_count + 16'd1;
        end
    end
`else
    // Counters absent in this build; the datapath above is unaffected.
`endif

endmodule
